// File: rtl/viterbi_traceback.sv
// Viterbi traceback unit.
// Walks the survivor RAM backwards from (i_start_page, i_start_state).
// The first TB_LEN steps are a training window with no output. The next
// DEC_LEN steps produce decoded bits, which are buffered and then emitted
// oldest-first. Each step takes two cycles: RD issues the read, CAP consumes
// the synchronous RAM data.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               trace request (sampled in IDLE only)
//   i_start_page          newest survivor page to trace from
//   i_start_state         best-metric state at i_start_page
//   o_ram_rd, o_ram_addr  survivor RAM read strobe / {page, state row}
//   i_ram_data            RAM word, valid the cycle after o_ram_rd
//   o_decoded_bit/valid   decoded bit stream, oldest bit first
//   o_done                high together with the last decoded bit
//   o_busy                high from start acceptance until back in IDLE
module viterbi_traceback #(
  parameter int WD_FSM      = 6,
  parameter int WD_DEPTH    = 4,
  parameter int WD_RAM_DATA = 8,
  parameter int TB_LEN      = 8,
  parameter int DEC_LEN     = 4
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic                                              i_start,
  input  logic [WD_DEPTH-1:0]                               i_start_page,
  input  logic [WD_FSM-1:0]                                 i_start_state,
  output logic                                              o_ram_rd,
  output logic [WD_DEPTH+WD_FSM-$clog2(WD_RAM_DATA)-1:0]    o_ram_addr,
  input  logic [WD_RAM_DATA-1:0]                            i_ram_data,
  output logic                                              o_decoded_bit,
  output logic                                              o_decoded_valid,
  output logic                                              o_done,
  output logic                                              o_busy
);
  localparam int SELW = $clog2(WD_RAM_DATA);
  localparam int N    = TB_LEN + DEC_LEN;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int OW   = (DEC_LEN > 1) ? $clog2(DEC_LEN) : 1;
  localparam int AW   = WD_DEPTH + WD_FSM - SELW;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_OUT} state_t;

  state_t               r_fsm;
  logic [WD_FSM-1:0]    r_cur;
  logic [WD_DEPTH-1:0]  r_page;
  logic [KW-1:0]        r_k;
  logic [OW-1:0]        r_oc;
  logic [DEC_LEN-1:0]   r_buf;
  logic                 r_ram_rd;
  logic [AW-1:0]        r_ram_addr;
  logic                 r_bit;
  logic                 r_valid;
  logic                 r_done;
  logic                 r_busy;

  logic                 w_s;
  logic [WD_FSM-1:0]    w_nxt;
  logic [WD_DEPTH-1:0]  w_page_nxt;
  logic [OW-1:0]        w_widx;
  logic [OW-1:0]        w_oc_nxt;
  logic                 w_last;
  logic                 w_in_dec;

  // Survivor bit for the current state, then shift it in as the predecessor LSB.
  assign w_s        = i_ram_data[r_cur[SELW-1:0]];
  assign w_nxt      = {r_cur[WD_FSM-2:0], w_s};
  assign w_page_nxt = r_page - 1'b1;
  assign w_widx     = OW'(r_k - KW'(TB_LEN));
  assign w_oc_nxt   = r_oc - 1'b1;
  assign w_last     = (r_k == KW'(N - 1));
  assign w_in_dec   = (r_k >= KW'(TB_LEN));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm      <= S_IDLE;
      r_cur      <= '0;
      r_page     <= '0;
      r_k        <= '0;
      r_oc       <= '0;
      r_buf      <= '0;
      r_ram_rd   <= 1'b0;
      r_ram_addr <= '0;
      r_bit      <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (i_start) begin
            r_cur      <= i_start_state;
            r_page     <= i_start_page;
            r_k        <= '0;
            r_ram_rd   <= 1'b1;
            r_ram_addr <= {i_start_page, i_start_state[WD_FSM-1:SELW]};
            r_busy     <= 1'b1;
            r_fsm      <= S_RD;
          end
        end
        S_RD: begin
          r_ram_rd <= 1'b0;
          r_fsm    <= S_CAP;
        end
        S_CAP: begin
          if (w_in_dec) r_buf[w_widx] <= r_cur[WD_FSM-1];
          r_cur  <= w_nxt;
          r_page <= w_page_nxt;
          r_k    <= r_k + 1'b1;
          if (w_last) begin
            // Oldest buffered bit is the one being written this cycle, so
            // present it straight from r_cur rather than from r_buf.
            r_oc    <= OW'(DEC_LEN - 1);
            r_valid <= 1'b1;
            r_bit   <= r_cur[WD_FSM-1];
            r_done  <= (DEC_LEN == 1);
            r_fsm   <= S_OUT;
          end else begin
            r_ram_rd   <= 1'b1;
            r_ram_addr <= {w_page_nxt, w_nxt[WD_FSM-1:SELW]};
            r_fsm      <= S_RD;
          end
        end
        S_OUT: begin
          if (r_oc == '0) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_bit   <= 1'b0;
            r_busy  <= 1'b0;
            r_fsm   <= S_IDLE;
          end else begin
            r_oc   <= w_oc_nxt;
            r_bit  <= r_buf[w_oc_nxt];
            r_done <= (w_oc_nxt == '0);
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign o_ram_rd        = r_ram_rd;
  assign o_ram_addr      = r_ram_addr;
  assign o_decoded_bit   = r_bit;
  assign o_decoded_valid = r_valid;
  assign o_done          = r_done;
  assign o_busy          = r_busy;
endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback with default parameters.
module tb_viterbi_traceback;
  localparam int NS = 12;   // TB_LEN + DEC_LEN
  localparam int DL = 4;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] spage;
  logic [5:0] sstate;
  logic       ram_rd;
  logic [6:0] ram_addr;
  logic [7:0] ram_data;
  logic       dbit, dvalid, done, busy;

  logic [7:0] mem [0:127];

  int checks = 0, failures = 0;

  // observations of the last trace
  logic [6:0] obs_addr [0:31];
  int         obs_rdc  [0:31];
  logic       obs_bit  [0:15];
  int n_rd, n_bits, n_done, busy_cnt, first_valid, done_cyc, timeout;

  // reference results
  logic [6:0] exp_addr [0:NS-1];
  logic       exp_bit  [0:DL-1];

  viterbi_traceback dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_page(spage),
    .i_start_state(sstate), .o_ram_rd(ram_rd), .o_ram_addr(ram_addr),
    .i_ram_data(ram_data), .o_decoded_bit(dbit), .o_decoded_valid(dvalid),
    .o_done(done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // synchronous survivor RAM, one-cycle read latency
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  // Reference: follow the survivor path with integer arithmetic, collect the
  // state MSBs of the decode window, then emit them oldest (last step) first.
  task automatic model(input int pg, input int st);
    int s, p, w, dec [0:DL-1];
    s = st; p = pg;
    for (int j = 0; j < NS; j++) begin
      exp_addr[j] = 7'(p * 8 + s / 8);
      w = mem[p * 8 + s / 8];
      if (j >= NS - DL) dec[j - (NS - DL)] = s / 32;
      s = (s * 2) % 64 + ((w >> (s % 8)) & 1);
      p = (p + 15) % 16;
    end
    for (int i = 0; i < DL; i++) exp_bit[i] = dec[DL - 1 - i][0];
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 128; i++) mem[i] = v;
  endtask

  // Issue one Start and record everything until Busy drops. Cycle c is the
  // cycle between E(c) and E(c+1), E0 being the edge that samples Start.
  task automatic run_trace(input logic [3:0] pg, input logic [5:0] st, input int hold);
    @(negedge clk);
    spage = pg; sstate = st; start = 1'b1;
    @(posedge clk);
    n_rd = 0; n_bits = 0; n_done = 0; busy_cnt = 0;
    first_valid = -1; done_cyc = -1; timeout = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c >= hold) start = 1'b0;
      if (ram_rd && n_rd < 32) begin obs_addr[n_rd] = ram_addr; obs_rdc[n_rd] = c; n_rd++; end
      if (dvalid && n_bits < 16) begin
        if (n_bits == 0) first_valid = c;
        obs_bit[n_bits] = dbit; n_bits++;
      end
      if (done) begin n_done++; done_cyc = c; end
      if (busy) busy_cnt++;
      else begin timeout = 0; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; spage = '0; sstate = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_rd, ram_addr, dbit, dvalid, done, busy} !== 12'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {ram_rd, ram_addr, dbit, dvalid, done, busy});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_rd, dvalid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=000", {ram_rd, dvalid, busy});
    end
  endtask

  task automatic test_all_zero();
    fill_const(8'h00);
    run_trace(4'd5, 6'd0, 0);
    model(5, 0);
    checks++;
    if (timeout != 0 || n_rd != NS) begin
      failures++; $display("FAIL zero_nreads got=%0d exp=%0d timeout=%0d", n_rd, NS, timeout);
    end
    for (int j = 0; j < NS && j < n_rd; j++) begin
      checks++;
      if (obs_addr[j] !== 7'(((5 - j + 16) % 16) * 8) || obs_addr[j] !== exp_addr[j]) begin
        failures++; $display("FAIL zero_addr[%0d] got=%h exp=%h", j, obs_addr[j], exp_addr[j]);
      end
      checks++;
      if (obs_rdc[j] != 2 * j) begin
        failures++; $display("FAIL zero_rd_cycle[%0d] got=%0d exp=%0d", j, obs_rdc[j], 2 * j);
      end
    end
    checks++;
    if (n_bits != DL) begin failures++; $display("FAIL zero_nbits got=%0d exp=%0d", n_bits, DL); end
    for (int i = 0; i < DL && i < n_bits; i++) begin
      checks++;
      if (obs_bit[i] !== 1'b0) begin failures++; $display("FAIL zero_bit[%0d] got=%b exp=0", i, obs_bit[i]); end
    end
    checks++;
    if (first_valid != 2 * NS) begin
      failures++; $display("FAIL zero_valid_start got=%0d exp=%0d", first_valid, 2 * NS);
    end
    checks++;
    if (n_done != 1 || done_cyc != 2 * NS + DL - 1) begin
      failures++; $display("FAIL zero_done got=%0d@%0d exp=1@%0d", n_done, done_cyc, 2 * NS + DL - 1);
    end
    checks++;
    if (busy_cnt != 28) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=28", busy_cnt); end
  endtask

  task automatic test_all_ones();
    logic [3:0] pg;
    pg = 4'($urandom);
    fill_const(8'hFF);
    run_trace(pg, 6'h3F, 0);
    model(int'(pg), 63);
    checks++;
    if (n_rd != NS || timeout != 0) begin failures++; $display("FAIL ones_nreads got=%0d exp=%0d", n_rd, NS); end
    for (int j = 0; j < NS && j < n_rd; j++) begin
      checks++;
      if (obs_addr[j][2:0] !== 3'd7 || obs_addr[j] !== exp_addr[j]) begin
        failures++; $display("FAIL ones_addr[%0d] got=%h exp=%h", j, obs_addr[j], exp_addr[j]);
      end
    end
    for (int i = 0; i < DL; i++) begin
      checks++;
      if (i >= n_bits || obs_bit[i] !== 1'b1) begin
        failures++; $display("FAIL ones_bit[%0d] got=%b exp=1", i, obs_bit[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [5:0] st;
    st = 6'($urandom);
    fill_rand();
    run_trace(4'd2, st, 0);
    model(2, int'(st));
    checks++;
    if (n_rd != NS || timeout != 0) begin failures++; $display("FAIL wrap_nreads got=%0d exp=%0d", n_rd, NS); end
    for (int j = 0; j < NS && j < n_rd; j++) begin
      checks++;
      if (obs_addr[j][6:3] !== 4'((2 - j + 16) % 16) || obs_addr[j] !== exp_addr[j]) begin
        failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", j, obs_addr[j], exp_addr[j]);
      end
    end
    for (int i = 0; i < DL; i++) begin
      checks++;
      if (i >= n_bits || obs_bit[i] !== exp_bit[i]) begin
        failures++; $display("FAIL wrap_bit[%0d] got=%b exp=%b", i, obs_bit[i], exp_bit[i]);
      end
    end
  endtask

  task automatic test_bitsel();
    logic [3:0] p, pm1;
    p = 4'($urandom); pm1 = p - 4'd1;
    fill_const(8'h00);
    mem[{p, 3'd4}] = 8'h01;
    run_trace(p, 6'h20, 0);
    model(int'(p), 32);
    checks++;
    if (n_rd < 2 || obs_addr[0] !== {p, 3'd4} || obs_addr[1] !== {pm1, 3'd0}) begin
      failures++; $display("FAIL bitsel_first_addrs got=%h,%h exp=%h,%h",
                           obs_addr[0], obs_addr[1], {p, 3'd4}, {pm1, 3'd0});
    end
    for (int j = 0; j < NS && j < n_rd; j++) begin
      checks++;
      if (obs_addr[j] !== exp_addr[j]) begin
        failures++; $display("FAIL bitsel_addr[%0d] got=%h exp=%h", j, obs_addr[j], exp_addr[j]);
      end
    end
    for (int i = 0; i < DL; i++) begin
      checks++;
      if (i >= n_bits || obs_bit[i] !== 1'b0) begin
        failures++; $display("FAIL bitsel_bit[%0d] got=%b exp=0", i, obs_bit[i]);
      end
    end
  endtask

  // Plant a path whose states at steps 8..11 have MSBs 1,0,1,1.
  task automatic test_walking();
    int s, p, pg, st, b [0:NS-1];
    logic ref_out [0:DL-1];
    ref_out = '{1'b1, 1'b1, 1'b0, 1'b1};
    pg = int'($urandom_range(15, 0)); st = int'($urandom_range(63, 0));
    for (int j = 0; j < NS; j++) b[j] = int'($urandom_range(1, 0));
    b[2] = 1; b[3] = 0; b[4] = 1; b[5] = 1;   // MSB of state j is b[j-6]
    fill_rand();
    s = st; p = pg;
    for (int j = 0; j < NS; j++) begin
      mem[p * 8 + s / 8][s % 8] = b[j][0];
      s = (s * 2) % 64 + b[j];
      p = (p + 15) % 16;
    end
    run_trace(4'(pg), 6'(st), 0);
    for (int i = 0; i < DL; i++) begin
      checks++;
      if (i >= n_bits || obs_bit[i] !== ref_out[i]) begin
        failures++; $display("FAIL walk_bit[%0d] got=%b exp=%b", i, obs_bit[i], ref_out[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] pg; logic [5:0] st;
    for (int t = 0; t < 4; t++) begin
      pg = 4'($urandom); st = 6'($urandom);
      fill_rand();
      run_trace(pg, st, 0);
      model(int'(pg), int'(st));
      checks++;
      if (n_rd != NS || busy_cnt != 28 || timeout != 0) begin
        failures++; $display("FAIL rand%0d_shape reads=%0d busy=%0d exp=%0d/28", t, n_rd, busy_cnt, NS);
      end
      for (int j = 0; j < NS && j < n_rd; j++) begin
        checks++;
        if (obs_addr[j] !== exp_addr[j]) begin
          failures++; $display("FAIL rand%0d_addr[%0d] got=%h exp=%h", t, j, obs_addr[j], exp_addr[j]);
        end
      end
      for (int i = 0; i < DL; i++) begin
        checks++;
        if (i >= n_bits || obs_bit[i] !== exp_bit[i]) begin
          failures++; $display("FAIL rand%0d_bit[%0d] got=%b exp=%b", t, i, obs_bit[i], exp_bit[i]);
        end
      end
    end
  endtask

  task automatic test_start_hold();
    logic [3:0] pg; logic [5:0] st;
    pg = 4'($urandom); st = 6'($urandom);
    fill_rand();
    run_trace(pg, st, 10);   // Start stays high for 10 cycles into the trace
    model(int'(pg), int'(st));
    checks++;
    if (n_rd != NS || busy_cnt != 28 || obs_addr[0] !== exp_addr[0]) begin
      failures++; $display("FAIL hold_shape reads=%0d busy=%0d exp=%0d/28", n_rd, busy_cnt, NS);
    end
    for (int i = 0; i < DL; i++) begin
      checks++;
      if (i >= n_bits || obs_bit[i] !== exp_bit[i]) begin
        failures++; $display("FAIL hold_bit[%0d] got=%b exp=%b", i, obs_bit[i], exp_bit[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] pg; logic [5:0] st;
    fill_rand();
    @(negedge clk); spage = 4'($urandom); sstate = 6'($urandom); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (13) @(negedge clk);   // cycle 12: step 6 read
    checks++;
    if (ram_rd !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL midreset_pre got=%b%b exp=11", ram_rd, busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ram_rd, ram_addr, dbit, dvalid, done, busy} !== 12'h0) begin
      failures++; $display("FAIL midreset_outputs got=%h exp=0", {ram_rd, ram_addr, dbit, dvalid, done, busy});
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_rd, dvalid, busy} !== 3'b000) begin
      failures++; $display("FAIL midreset_no_resume got=%b exp=000", {ram_rd, dvalid, busy});
    end
    pg = 4'($urandom); st = 6'($urandom);
    run_trace(pg, st, 0);
    model(int'(pg), int'(st));
    checks++;
    if (n_rd != NS || busy_cnt != 28 || first_valid != 2 * NS) begin
      failures++; $display("FAIL postreset_shape reads=%0d busy=%0d valid@%0d", n_rd, busy_cnt, first_valid);
    end
    for (int i = 0; i < DL; i++) begin
      checks++;
      if (i >= n_bits || obs_bit[i] !== exp_bit[i]) begin
        failures++; $display("FAIL postreset_bit[%0d] got=%b exp=%b", i, obs_bit[i], exp_bit[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pg; logic [5:0] st;
    for (int t = 0; t < 2; t++) begin
      pg = 4'($urandom); st = 6'($urandom);
      fill_rand();
      run_trace(pg, st, 0);
      model(int'(pg), int'(st));
      checks++;
      if (busy_cnt != 28 || n_done != 1 || timeout != 0) begin
        failures++; $display("FAIL b2b%0d_shape busy=%0d done=%0d exp=28/1", t, busy_cnt, n_done);
      end
      for (int i = 0; i < DL; i++) begin
        checks++;
        if (i >= n_bits || obs_bit[i] !== exp_bit[i]) begin
          failures++; $display("FAIL b2b%0d_bit[%0d] got=%b exp=%b", t, i, obs_bit[i], exp_bit[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_ones();
    test_wrap();
    test_bitsel();
    test_walking();
    test_random();
    test_start_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
